cursor_controller: RTL and testbench
====================================

# cursor_controller

Byte-stream command sequencer that owns the VT52 cursor position and drives the cursor_position registers (x and y) and the character buffer write port. It consumes received bytes over a valid/ready handshake, parses printable characters, CR/LF/BS and VT52 escape sequences, and emits one-cycle cursor-write and char-write strobes. It also requests a screen scroll when the cursor leaves the bottom row. It sits between the serial receiver and the cursor_position/char_generator blocks, all in the px_clk domain.

## Interface
- COL_BITS, 6, width of the column coordinate
- ROW_BITS, 4, width of the row coordinate
- LAST_COL, 63, highest valid column
- LAST_ROW, 15, highest valid row
- px_clk  input  1  pixel clock; all state changes on its rising edge
- clr_n  input  1  reset, asynchronous, active-low; one clock, px_clk
- in_data  input  8  received byte
- in_valid  input  1  in_data valid
- in_ready  output  1  byte accepted when in_valid & in_ready at a rising edge
- new_cursor_x  output  COL_BITS  cursor column to load
- new_cursor_y  output  ROW_BITS  cursor row to load
- write_cursor_pos  output  1  one-cycle load strobe for both cursor registers
- char_we  output  1  one-cycle character write strobe
- char_data  output  8  character to write
- char_col  output  COL_BITS  write column
- char_row  output  ROW_BITS  write row
- scroll_req  output  1  scroll request, held until acknowledged
- scroll_ack  input  1  scroll done

## Operation
- Shadow position (col, row) is driven on new_cursor_x/new_cursor_y at all times.
- States: IDLE, ESC, ESC_Y_ROW, ESC_Y_COL.
- IDLE, printable 0x20–0x7E: char_we=1, char_data=byte, char_col/char_row=pre-advance position. Advance: col<LAST_COL → col+1; else col=0 and row+1. At row==LAST_ROW, row stays and scroll_req is set.
- IDLE, 0x0D (CR): col=0. 0x0A (LF): row+1, or scroll_req at LAST_ROW. 0x08 (BS): col−1, saturating at 0. 0x1B: go to ESC with no write. Other bytes are discarded with no strobes.
- ESC: 'A' row−1 (saturate 0); 'B' row+1 (saturate LAST_ROW, no scroll); 'C' col+1 (saturate LAST_COL); 'D' col−1 (saturate 0); 'H' home (0,0). Each of these returns to IDLE.
- ESC: 'Y' goes to ESC_Y_ROW (see Configuration). 0x1B stays in ESC. Any other byte is discarded and returns to IDLE.
- ESC_Y_ROW: latch v=byte−0x20, then go to ESC_Y_COL.
- ESC_Y_COL: h=byte−0x20. Each axis is updated only if its value is in range (byte ≥0x20 and value ≤ LAST_*); otherwise that axis is unchanged. Return to IDLE.
- write_cursor_pos pulses for every accepted byte that executes a cursor command or printable char. The pulse is issued even when a saturated move leaves the position unchanged. It does not pulse for ESC prefix bytes, ESC_Y_ROW, or discarded bytes.
- in_ready = ~scroll_req.

## Timing
- Reset (clr_n low, async): col=row=0, state IDLE, write_cursor_pos=0, char_we=0, char_data=0, char_col=char_row=0, scroll_req=0, so in_ready=1.
- Byte accepted at edge N:
  - The new shadow position, write_cursor_pos and char_we are registered at edge N and high for exactly cycle N..N+1.
  - cursor_position loads at edge N+1.
- Throughput is one byte per cycle while no scroll is pending.
- scroll_req rises at edge N and stays high; in_ready is low from the same cycle.
- scroll_ack is sampled from edge N+1 onward. The first edge with scroll_ack=1 clears scroll_req. A byte presented at that edge is not accepted.
- scroll_ack while scroll_req=0 is ignored.
- Reset mid-sequence (e.g. in ESC_Y_COL or with scroll pending) discards the partial command and clears the pending scroll.

## Configuration
- CURSOR_CTRL_DIRECT_ADDR_EN defined: ESC Y row col direct addressing is supported as above.
- Not defined: ESC_Y_ROW/ESC_Y_COL are not built. 'Y' in ESC is discarded like any unknown byte (→IDLE), so the following two bytes are handled in IDLE (printed if printable).

## Test plan
- Reset, then send 'A' (0x41) → char_we with data 0x41 at (0,0); write_cursor_pos with new_cursor_x=1, y=0 one cycle later-registered; exactly one pulse each.
- Send 64 printable bytes at row 15, then 0x0A at row 15 → wrap to col 0 with scroll_req=1; hold scroll_ack=0 for 5 cycles → in_ready=0, no acceptance; ack → scroll_req=0, row stays 15.
- Send ESC Y 0x25 0x2A → cursor (x=10, y=5). Send ESC Y 0x40 0x21 → y unchanged (32>15), x=1.
- From (0,0): ESC A, ESC D, BS → position stays (0,0), three write_cursor_pos pulses, no char_we.
- Send ESC Q, then 'B' → 'Q' discarded; 'B' printed at the current position.
- Assert clr_n low while in ESC_Y_COL with scroll_req high → all outputs at reset values, in_ready=1. Repeat with the macro undefined: ESC Y 0x25 0x2A prints '%' and '*'.

Source files
------------

// File: rtl/cursor_controller.sv
// cursor_controller: VT52 byte-stream command sequencer.
//
// Consumes received bytes over a valid/ready handshake, keeps the shadow
// cursor position (col,row), and issues one-cycle strobes that load the
// cursor_position registers and write the character buffer. Requests a
// screen scroll when the cursor would leave the bottom row and stalls input
// until the scroll is acknowledged.
//
// Optional feature macro: CURSOR_CTRL_DIRECT_ADDR_EN
//   defined     -> ESC Y <row+0x20> <col+0x20> direct addressing is built
//   not defined -> 'Y' after ESC is discarded like any unknown byte
//
// Ports:
//   px_clk           in   pixel clock, rising-edge active
//   clr_n            in   asynchronous active-low reset
//   in_data          in   received byte
//   in_valid         in   in_data valid
//   in_ready         out  byte accepted when in_valid & in_ready
//   new_cursor_x     out  shadow column (load value for cursor_position x)
//   new_cursor_y     out  shadow row (load value for cursor_position y)
//   write_cursor_pos out  one-cycle load strobe for both cursor registers
//   char_we          out  one-cycle character write strobe
//   char_data        out  character to write
//   char_col         out  write column
//   char_row         out  write row
//   scroll_req       out  scroll request, held until scroll_ack
//   scroll_ack       in   scroll done
module cursor_controller #(
  parameter int unsigned COL_BITS = 6,
  parameter int unsigned ROW_BITS = 4,
  parameter int unsigned LAST_COL = 63,
  parameter int unsigned LAST_ROW = 15
) (
  input  logic                px_clk,
  input  logic                clr_n,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [COL_BITS-1:0] new_cursor_x,
  output logic [ROW_BITS-1:0] new_cursor_y,
  output logic                write_cursor_pos,
  output logic                char_we,
  output logic [7:0]          char_data,
  output logic [COL_BITS-1:0] char_col,
  output logic [ROW_BITS-1:0] char_row,
  output logic                scroll_req,
  input  logic                scroll_ack
);

  localparam logic [COL_BITS-1:0] LAST_COL_C = COL_BITS'(LAST_COL);
  localparam logic [ROW_BITS-1:0] LAST_ROW_C = ROW_BITS'(LAST_ROW);
  localparam logic [COL_BITS-1:0] COL_ONE    = COL_BITS'(1);
  localparam logic [ROW_BITS-1:0] ROW_ONE    = ROW_BITS'(1);

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_ESC = 8'h1B;

`ifdef CURSOR_CTRL_DIRECT_ADDR_EN
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ESC       = 2'd1,
    ST_ESC_Y_ROW = 2'd2,
    ST_ESC_Y_COL = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ESC  = 2'd1
  } state_e;
`endif

  state_e              state_q, state_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic                wcp_q, wcp_d;
  logic                char_we_q, char_we_d;
  logic [7:0]          char_data_q, char_data_d;
  logic [COL_BITS-1:0] char_col_q, char_col_d;
  logic [ROW_BITS-1:0] char_row_q, char_row_d;
  logic                scroll_q, scroll_d;
`ifdef CURSOR_CTRL_DIRECT_ADDR_EN
  logic [7:0]          yrow_q, yrow_d;
`endif

  logic accept;
  assign accept = in_valid & ~scroll_q;

  // Next-state, position update and strobe generation
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    wcp_d       = 1'b0;
    char_we_d   = 1'b0;
    char_data_d = char_data_q;
    char_col_d  = char_col_q;
    char_row_d  = char_row_q;
    scroll_d    = scroll_q;
`ifdef CURSOR_CTRL_DIRECT_ADDR_EN
    yrow_d      = yrow_q;
`endif

    // Ack only matters while a request is outstanding
    if (scroll_q && scroll_ack) begin
      scroll_d = 1'b0;
    end

    // accept implies scroll_q==0, so setting scroll_d below cannot race the ack
    if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            char_we_d   = 1'b1;
            char_data_d = in_data;
            char_col_d  = col_q;
            char_row_d  = row_q;
            wcp_d       = 1'b1;
            if (col_q < LAST_COL_C) begin
              col_d = col_q + COL_ONE;
            end else begin
              col_d = '0;
              if (row_q < LAST_ROW_C) row_d = row_q + ROW_ONE;
              else                    scroll_d = 1'b1;
            end
          end else begin
            unique case (in_data)
              CH_CR: begin
                col_d = '0;
                wcp_d = 1'b1;
              end
              CH_LF: begin
                wcp_d = 1'b1;
                if (row_q < LAST_ROW_C) row_d = row_q + ROW_ONE;
                else                    scroll_d = 1'b1;
              end
              CH_BS: begin
                wcp_d = 1'b1;
                if (col_q != '0) col_d = col_q - COL_ONE;
              end
              CH_ESC:  state_d = ST_ESC;
              default: ;
            endcase
          end
        end

        ST_ESC: begin
          state_d = ST_IDLE;
          unique case (in_data)
            8'h41: begin  // 'A' up
              wcp_d = 1'b1;
              if (row_q != '0) row_d = row_q - ROW_ONE;
            end
            8'h42: begin  // 'B' down, no scroll
              wcp_d = 1'b1;
              if (row_q < LAST_ROW_C) row_d = row_q + ROW_ONE;
            end
            8'h43: begin  // 'C' right
              wcp_d = 1'b1;
              if (col_q < LAST_COL_C) col_d = col_q + COL_ONE;
            end
            8'h44: begin  // 'D' left
              wcp_d = 1'b1;
              if (col_q != '0) col_d = col_q - COL_ONE;
            end
            8'h48: begin  // 'H' home
              wcp_d = 1'b1;
              col_d = '0;
              row_d = '0;
            end
`ifdef CURSOR_CTRL_DIRECT_ADDR_EN
            8'h59: state_d = ST_ESC_Y_ROW;  // 'Y'
`endif
            CH_ESC:  state_d = ST_ESC;
            default: ;
          endcase
        end

`ifdef CURSOR_CTRL_DIRECT_ADDR_EN
        // Keep the raw row byte; range check happens with the column byte
        ST_ESC_Y_ROW: begin
          yrow_d  = in_data;
          state_d = ST_ESC_Y_COL;
        end

        // Each axis updates independently, only when its value is in range
        ST_ESC_Y_COL: begin
          wcp_d   = 1'b1;
          state_d = ST_IDLE;
          if (yrow_q >= 8'h20 && (yrow_q - 8'h20) <= 8'(LAST_ROW)) begin
            row_d = ROW_BITS'(yrow_q - 8'h20);
          end
          if (in_data >= 8'h20 && (in_data - 8'h20) <= 8'(LAST_COL)) begin
            col_d = COL_BITS'(in_data - 8'h20);
          end
        end
`endif

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge px_clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      wcp_q       <= 1'b0;
      char_we_q   <= 1'b0;
      char_data_q <= '0;
      char_col_q  <= '0;
      char_row_q  <= '0;
      scroll_q    <= 1'b0;
`ifdef CURSOR_CTRL_DIRECT_ADDR_EN
      yrow_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      wcp_q       <= wcp_d;
      char_we_q   <= char_we_d;
      char_data_q <= char_data_d;
      char_col_q  <= char_col_d;
      char_row_q  <= char_row_d;
      scroll_q    <= scroll_d;
`ifdef CURSOR_CTRL_DIRECT_ADDR_EN
      yrow_q      <= yrow_d;
`endif
    end
  end

  assign in_ready         = ~scroll_q;
  assign new_cursor_x     = col_q;
  assign new_cursor_y     = row_q;
  assign write_cursor_pos = wcp_q;
  assign char_we          = char_we_q;
  assign char_data        = char_data_q;
  assign char_col         = char_col_q;
  assign char_row         = char_row_q;
  assign scroll_req       = scroll_q;

endmodule

// File: tb/tb_cursor_controller.sv
// Directed testbench for cursor_controller. Expectations are hand-computed
// for the 64x16 default geometry; the direct-addressing section follows
// CURSOR_CTRL_DIRECT_ADDR_EN.
module tb_cursor_controller;

  logic       px_clk;
  logic       clr_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] new_cursor_x;
  logic [3:0] new_cursor_y;
  logic       write_cursor_pos;
  logic       char_we;
  logic [7:0] char_data;
  logic [5:0] char_col;
  logic [3:0] char_row;
  logic       scroll_req;
  logic       scroll_ack;

  int n_cmp = 0;
  int n_err = 0;

  cursor_controller dut (
    .px_clk           (px_clk),
    .clr_n            (clr_n),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .new_cursor_x     (new_cursor_x),
    .new_cursor_y     (new_cursor_y),
    .write_cursor_pos (write_cursor_pos),
    .char_we          (char_we),
    .char_data        (char_data),
    .char_col         (char_col),
    .char_row         (char_row),
    .scroll_req       (scroll_req),
    .scroll_ack       (scroll_ack)
  );

  initial px_clk = 1'b0;
  always #5 px_clk = ~px_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte; returns #1 after the accepting edge
  task automatic send(input logic [7:0] b);
    int t;
    @(negedge px_clk);
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge px_clk);
      t++;
    end
    if (!in_ready) begin
      check("send_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge px_clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_x"},      32'(new_cursor_x), 0);
    check({tag, "_y"},      32'(new_cursor_y), 0);
    check({tag, "_wcp"},    32'(write_cursor_pos), 0);
    check({tag, "_we"},     32'(char_we), 0);
    check({tag, "_data"},   32'(char_data), 0);
    check({tag, "_col"},    32'(char_col), 0);
    check({tag, "_row"},    32'(char_row), 0);
    check({tag, "_scroll"}, 32'(scroll_req), 0);
    check({tag, "_ready"},  32'(in_ready), 1);
  endtask

`ifdef CURSOR_CTRL_DIRECT_ADDR_EN
  localparam int EXP_BX = 1;
  localparam int EXP_BY = 5;
`else
  localparam int EXP_BX = 4;
  localparam int EXP_BY = 0;
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    scroll_ack = 1'b0;
    #12;
    check_reset_state("rst");
    @(negedge px_clk);
    clr_n = 1'b1;

    // Printable 'A' at (0,0)
    send(8'h41);
    check("A_we",   32'(char_we), 1);
    check("A_data", 32'(char_data), 32'h41);
    check("A_col",  32'(char_col), 0);
    check("A_row",  32'(char_row), 0);
    check("A_wcp",  32'(write_cursor_pos), 1);
    check("A_x",    32'(new_cursor_x), 1);
    check("A_y",    32'(new_cursor_y), 0);
    @(posedge px_clk); #1;
    check("A_wcp_end", 32'(write_cursor_pos), 0);
    check("A_we_end",  32'(char_we), 0);

    // CR
    send(8'h0D);
    check("CR_x",   32'(new_cursor_x), 0);
    check("CR_wcp", 32'(write_cursor_pos), 1);
    check("CR_we",  32'(char_we), 0);

    // 15 LF down to bottom row, no scroll yet
    repeat (15) send(8'h0A);
    check("LF15_y",      32'(new_cursor_y), 15);
    check("LF15_scroll", 32'(scroll_req), 0);

    // Full bottom row: last char wraps and requests scroll
    for (int i = 0; i < 64; i++) begin
      send(8'h30 + 8'(i % 10));
      check("row_col", 32'(char_col), 32'(i));
      check("row_row", 32'(char_row), 15);
    end
    check("wrap_x",      32'(new_cursor_x), 0);
    check("wrap_y",      32'(new_cursor_y), 15);
    check("wrap_scroll", 32'(scroll_req), 1);
    check("wrap_ready",  32'(in_ready), 0);

    // Stall with LF offered and no ack
    @(negedge px_clk);
    in_data  = 8'h0A;
    in_valid = 1'b1;
    repeat (5) begin
      @(posedge px_clk); #1;
      check("stall_wcp",    32'(write_cursor_pos), 0);
      check("stall_scroll", 32'(scroll_req), 1);
      check("stall_ready",  32'(in_ready), 0);
    end
    @(negedge px_clk);
    scroll_ack = 1'b1;
    @(posedge px_clk); #1;
    check("ack_scroll", 32'(scroll_req), 0);
    check("ack_noacc",  32'(write_cursor_pos), 0);
    check("ack_y",      32'(new_cursor_y), 15);
    check("ack_ready",  32'(in_ready), 1);
    @(negedge px_clk);
    scroll_ack = 1'b0;
    @(posedge px_clk); #1;
    in_valid = 1'b0;
    check("LFb_wcp",    32'(write_cursor_pos), 1);
    check("LFb_scroll", 32'(scroll_req), 1);
    check("LFb_y",      32'(new_cursor_y), 15);
    check("LFb_x",      32'(new_cursor_x), 0);
    @(negedge px_clk);
    scroll_ack = 1'b1;
    @(posedge px_clk); #1;
    check("ack2_scroll", 32'(scroll_req), 0);
    @(negedge px_clk);
    scroll_ack = 1'b0;
    @(negedge px_clk);
    scroll_ack = 1'b1;
    @(posedge px_clk); #1;
    check("stray_ack", 32'(scroll_req), 0);
    @(negedge px_clk);
    scroll_ack = 1'b0;

    // ESC H home
    send(8'h1B);
    check("esc_prefix_wcp", 32'(write_cursor_pos), 0);
    send(8'h48);
    check("H_wcp", 32'(write_cursor_pos), 1);
    check("H_x",   32'(new_cursor_x), 0);
    check("H_y",   32'(new_cursor_y), 0);

    // Saturating moves at (0,0)
    send(8'h1B); send(8'h41);
    check("escA_wcp", 32'(write_cursor_pos), 1);
    check("escA_y",   32'(new_cursor_y), 0);
    send(8'h1B); send(8'h44);
    check("escD_wcp", 32'(write_cursor_pos), 1);
    check("escD_x",   32'(new_cursor_x), 0);
    send(8'h08);
    check("BS_wcp", 32'(write_cursor_pos), 1);
    check("BS_x",   32'(new_cursor_x), 0);
    check("BS_we",  32'(char_we), 0);

    // ESC C / ESC B, then home
    send(8'h1B); send(8'h43);
    check("escC_x", 32'(new_cursor_x), 1);
    send(8'h1B); send(8'h42);
    check("escB_y", 32'(new_cursor_y), 1);
    send(8'h1B); send(8'h48);
    check("H2_x", 32'(new_cursor_x), 0);
    check("H2_y", 32'(new_cursor_y), 0);

`ifdef CURSOR_CTRL_DIRECT_ADDR_EN
    send(8'h1B); send(8'h59);
    check("Y_wcp", 32'(write_cursor_pos), 0);
    send(8'h25);
    check("Yrow_wcp", 32'(write_cursor_pos), 0);
    check("Yrow_we",  32'(char_we), 0);
    send(8'h2A);
    check("Ycol_wcp", 32'(write_cursor_pos), 1);
    check("Y_x",      32'(new_cursor_x), 10);
    check("Y_y",      32'(new_cursor_y), 5);
    check("Y_we",     32'(char_we), 0);
    send(8'h1B); send(8'h59); send(8'h40); send(8'h21);
    check("Yoor_x", 32'(new_cursor_x), 1);
    check("Yoor_y", 32'(new_cursor_y), 5);
`else
    send(8'h1B); send(8'h59);
    check("Y_wcp", 32'(write_cursor_pos), 0);
    send(8'h25);
    check("pct_we",   32'(char_we), 1);
    check("pct_data", 32'(char_data), 32'h25);
    check("pct_col",  32'(char_col), 0);
    send(8'h2A);
    check("ast_data", 32'(char_data), 32'h2A);
    check("ast_col",  32'(char_col), 1);
    check("ast_x",    32'(new_cursor_x), 2);
    send(8'h1B); send(8'h59); send(8'h40); send(8'h21);
    check("excl_col", 32'(char_col), 3);
    check("excl_x",   32'(new_cursor_x), 4);
    check("excl_y",   32'(new_cursor_y), 0);
`endif

    // Unknown ESC byte discarded, following byte printed
    send(8'h1B); send(8'h51);
    check("escQ_wcp", 32'(write_cursor_pos), 0);
    check("escQ_we",  32'(char_we), 0);
    send(8'h42);
    check("B_we",   32'(char_we), 1);
    check("B_data", 32'(char_data), 32'h42);
    check("B_col",  32'(char_col), 32'(EXP_BX));
    check("B_row",  32'(char_row), 32'(EXP_BY));

    // Reset with scroll pending
    send(8'h1B); send(8'h48);
    repeat (15) send(8'h0A);
    send(8'h0A);
    check("pre_rst_scroll", 32'(scroll_req), 1);
    @(negedge px_clk);
    #2 clr_n = 1'b0;
    #1 check_reset_state("rst_scroll");
    @(negedge px_clk);
    clr_n = 1'b1;

    // Reset in the middle of an escape sequence
`ifdef CURSOR_CTRL_DIRECT_ADDR_EN
    send(8'h1B); send(8'h59); send(8'h25);
`else
    send(8'h1B);
`endif
    @(negedge px_clk);
    #2 clr_n = 1'b0;
    #1 check_reset_state("rst_esc");
    @(negedge px_clk);
    clr_n = 1'b1;
    send(8'h2A);
    check("post_rst_we",   32'(char_we), 1);
    check("post_rst_data", 32'(char_data), 32'h2A);
    check("post_rst_col",  32'(char_col), 0);
    check("post_rst_x",    32'(new_cursor_x), 1);
    check("post_rst_y",    32'(new_cursor_y), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
